// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared constants for the multicycle RISC-V control unit,
// datapath and ALU. Holds the 12-state FSM enum, the ALU-decoder class enum,
// opcode constants, ALU control codes and datapath mux-select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Which decode table the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD    = 2'd0,
    ALU_CLS_BRANCH = 2'd1,
    ALU_CLS_RTYPE  = 2'd2,
    ALU_CLS_ITYPE  = 2'd3
  } alu_class_t;

  // Opcodes
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU control codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;

  // Mux selects
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: combinational ALU-control decoder.
//   i_alu_class : decode table selected by the FSM state
//   i_funct3    : instruction bits [14:12]
//   i_funct7b5  : instruction bit 30
//   o_alu_control : 4-bit ALU operation code
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_t i_alu_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_class)
      ALU_CLS_ADD: o_alu_control = ALU_ADD;
      ALU_CLS_BRANCH: begin
        // beq/bne compare by subtraction, signed and unsigned ordering use slt/sltu
        case (i_funct3[2:1])
          2'b10:   o_alu_control = ALU_SLT;
          2'b11:   o_alu_control = ALU_SLTU;
          default: o_alu_control = ALU_SUB;
        endcase
      end
      ALU_CLS_RTYPE, ALU_CLS_ITYPE: begin
        case (i_funct3)
          // funct7b5 selects sub only for R-type; in I-ALU it is immediate bits
          3'b000: o_alu_control = (i_alu_class == ALU_CLS_RTYPE && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_control = ALU_SLL;
          3'b010: o_alu_control = ALU_SLT;
          3'b011: o_alu_control = ALU_SLTU;
          3'b100: o_alu_control = ALU_XOR;
          3'b101: o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore-FSM control unit for the multicycle RISC-V core.
// Inputs : clk, rst_n (async active-low), op, funct3, funct7b5 (from IR),
//          zero (ALU flag), mem_ready (memory access done this cycle).
// Outputs: pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//          alu_src_b, alu_control, reg_write, illegal_instr (sticky trap),
//          dbg_state (current FSM state encoding).
//
// Memory handshake: a memory access is requested for as long as the FSM sits
// in FETCH, MEMREAD or MEMWRITE; mem_ready high in such a cycle means the
// access completes on the next rising edge, and the FSM leaves the state on
// that edge. mem_ready is ignored in every other state.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] dbg_state
);

  state_t     r_state;
  state_t     w_decode_next;
  alu_class_t w_alu_class;
  logic       w_mem_ready;
  logic       w_branch_taken;

  // Masking with rst_n keeps the FETCH strobes low while reset is held.
  assign w_mem_ready = mem_ready & rst_n;
  assign dbg_state   = r_state;

  always_comb begin
    w_decode_next = S_ILLEGAL;
    case (op)
      OP_LW, OP_SW: w_decode_next = S_MEMADR;
      OP_RTYPE:     w_decode_next = S_EXECUTER;
      OP_ITYPE:     w_decode_next = S_EXECUTEI;
      OP_BRANCH:    w_decode_next = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
      OP_JAL:       w_decode_next = S_JAL;
      default:      w_decode_next = S_ILLEGAL;
    endcase
  end

  // beq/bge/bgeu take on zero; bne/blt/bltu take on !zero.
  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: w_branch_taken = zero;
      default:                w_branch_taken = ~zero;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_decode_next;
        S_MEMADR:   r_state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_ILLEGAL:  r_state <= S_ILLEGAL;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    adr_src       = ADR_PC;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    w_alu_class   = ALU_CLS_ADD;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = ADR_RESULT;
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_RESULT;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a   = SRCA_RS1;
        w_alu_class = ALU_CLS_RTYPE;
      end
      S_EXECUTEI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        w_alu_class = ALU_CLS_ITYPE;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        w_alu_class = ALU_CLS_BRANCH;
        pc_write    = w_branch_taken;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .i_alu_class   (w_alu_class),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_control)
  );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed testbench for riscv_multicycle_ctrl with hand-computed expectations.
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control, dbg_state;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .illegal_instr (illegal_instr),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; sampling happens 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7; cyc = 0;
  endtask

  // Run until back in FETCH (bounded) and check total cycles of the instruction.
  task automatic finish_instr(input string tag, input int exp_cyc);
    int guard = 0;
    while (dbg_state != 4'(S_FETCH) && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(dbg_state), 32'(S_FETCH));
    check("rst_illegal", 32'(illegal_instr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // reset outputs: FETCH with mem_ready masked
    check("rst_state0", 32'(dbg_state), 32'(S_FETCH));
    check("rst_irw", 32'(ir_write), 32'd0);
    check("rst_pcw", 32'(pc_write), 32'd0);
    check("rst_srcb", 32'(alu_src_b), 32'd2);
    check("rst_res", 32'(result_src), 32'd2);
    check("rst_aluc", 32'(alu_control), 32'd0);
    check("rst_ill0", 32'(illegal_instr), 32'd0);

    // sw stalled in MEMWRITE, then reset mid-access
    rst_n = 1'b1;
    set_instr(OP_SW, 3'b010, 1'b0);
    #1;
    check("fetch_irw", 32'(ir_write), 32'd1);
    check("fetch_pcw", 32'(pc_write), 32'd1);
    tick();
    check("dec_state", 32'(dbg_state), 32'(S_DECODE));
    check("dec_srca", 32'(alu_src_a), 32'd1);
    check("dec_srcb", 32'(alu_src_b), 32'd1);
    check("dec_irw", 32'(ir_write), 32'd0);
    mem_ready = 1'b0;
    tick();
    check("madr_srca", 32'(alu_src_a), 32'd2);
    tick();
    check("mw_state", 32'(dbg_state), 32'(S_MEMWRITE));
    check("mw_memw", 32'(mem_write), 32'd1);
    check("mw_adr", 32'(adr_src), 32'd1);
    tick();
    check("mw_hold", 32'(dbg_state), 32'(S_MEMWRITE));
    check("mw_hold_memw", 32'(mem_write), 32'd1);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(S_FETCH));
    check("mid_rst_memw", 32'(mem_write), 32'd0);
    check("mid_rst_irw", 32'(ir_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    #1;
    check("rel_irw", 32'(ir_write), 32'd1);
    check("rel_pcw", 32'(pc_write), 32'd1);
    tick();
    check("rel_dec", 32'(dbg_state), 32'(S_DECODE));
    tick();
    tick();
    check("sw_memw", 32'(mem_write), 32'd1);
    finish_instr("sw", 4);

    // R-type sub
    set_instr(OP_RTYPE, 3'b000, 1'b1);
    tick(); tick();
    check("sub_state", 32'(dbg_state), 32'(S_EXECUTER));
    check("sub_aluc", 32'(alu_control), 32'h1);
    check("sub_srca", 32'(alu_src_a), 32'd2);
    check("sub_srcb", 32'(alu_src_b), 32'd0);
    tick();
    check("sub_wb_regw", 32'(reg_write), 32'd1);
    check("sub_wb_res", 32'(result_src), 32'd0);
    finish_instr("sub", 4);

    // lw with 3 stall cycles in MEMREAD
    set_instr(OP_LW, 3'b010, 1'b0);
    tick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lw_memread", 32'(dbg_state), 32'(S_MEMREAD));
      check("lw_memread_regw", 32'(reg_write), 32'd0);
    end
    check("lw_memread_adr", 32'(adr_src), 32'd1);
    mem_ready = 1'b1;
    tick();
    check("lw_wb_regw", 32'(reg_write), 32'd1);
    check("lw_wb_res", 32'(result_src), 32'd1);
    finish_instr("lw", 8);
    check("lw_regw_once", 32'(reg_write), 32'd0);

    // blt not-zero: taken
    zero = 1'b0;
    set_instr(OP_BRANCH, 3'b100, 1'b0);
    tick(); tick();
    check("blt_aluc", 32'(alu_control), 32'h5);
    check("blt_pcw", 32'(pc_write), 32'd1);
    check("blt_srca", 32'(alu_src_a), 32'd2);
    finish_instr("blt", 3);

    // bgeu not-zero: not taken; zero flips it to taken
    set_instr(OP_BRANCH, 3'b111, 1'b0);
    tick(); tick();
    check("bgeu_aluc", 32'(alu_control), 32'h6);
    check("bgeu_pcw", 32'(pc_write), 32'd0);
    zero = 1'b1;
    #1;
    check("bgeu_z_pcw", 32'(pc_write), 32'd1);
    finish_instr("bgeu", 3);

    // bne with zero=1: not taken, sub
    set_instr(OP_BRANCH, 3'b001, 1'b0);
    tick(); tick();
    check("bne_aluc", 32'(alu_control), 32'h1);
    check("bne_pcw", 32'(pc_write), 32'd0);
    finish_instr("bne", 3);
    zero = 1'b0;

    // srai
    set_instr(OP_ITYPE, 3'b101, 1'b1);
    tick(); tick();
    check("srai_state", 32'(dbg_state), 32'(S_EXECUTEI));
    check("srai_aluc", 32'(alu_control), 32'h9);
    check("srai_srcb", 32'(alu_src_b), 32'd1);
    finish_instr("srai", 4);

    // addi with funct7b5=1 stays add
    set_instr(OP_ITYPE, 3'b000, 1'b1);
    tick(); tick();
    check("addi_aluc", 32'(alu_control), 32'h0);
    finish_instr("addi", 4);

    // R-type sll
    set_instr(OP_RTYPE, 3'b001, 1'b0);
    tick(); tick();
    check("sll_aluc", 32'(alu_control), 32'hA);
    finish_instr("sll", 4);

    // jal
    set_instr(OP_JAL, 3'b000, 1'b0);
    tick(); tick();
    check("jal_state", 32'(dbg_state), 32'(S_JAL));
    check("jal_pcw", 32'(pc_write), 32'd1);
    check("jal_srca", 32'(alu_src_a), 32'd1);
    check("jal_srcb", 32'(alu_src_b), 32'd2);
    check("jal_aluc", 32'(alu_control), 32'h0);
    tick();
    check("jal_wb_regw", 32'(reg_write), 32'd1);
    finish_instr("jal", 4);

    // illegal opcode: trap holds for 10 cycles until reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    zero = 1'b1;
    tick(); tick();
    check("ill_state", 32'(dbg_state), 32'(S_ILLEGAL));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ill_flag", 32'(illegal_instr), 32'd1);
      check("ill_strobes", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
    end
    pulse_reset();

    // branch with funct3 010 is illegal
    set_instr(OP_BRANCH, 3'b010, 1'b0);
    tick(); tick();
    check("br010_state", 32'(dbg_state), 32'(S_ILLEGAL));
    check("br010_flag", 32'(illegal_instr), 32'd1);
    pulse_reset();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
